// File: rtl/state_fetch_if.sv
// state_fetch_if: memory command/read-return port and caster word stream of the state fetcher
interface state_fetch_if #(
    parameter int ADDR_W = 30
);
    logic              cmd_en;
    logic [ADDR_W-1:0] cmd_addr;
    logic [5:0]        cmd_bl;
    logic              cmd_full;
    logic [31:0]       rd_data;
    logic              rd_valid;
    logic [31:0]       bi_pixel;
    logic              bi_valid;
    logic              bi_ready;

    modport master (
        output cmd_en, cmd_addr, cmd_bl, bi_pixel, bi_valid,
        input  cmd_full, rd_data, rd_valid, bi_ready
    );

    modport slave (
        input  cmd_en, cmd_addr, cmd_bl, bi_pixel, bi_valid,
        output cmd_full, rd_data, rd_valid, bi_ready
    );
endinterface

// File: rtl/state_fetch.sv
// state_fetch: burst-reads the state framebuffer into a credit-managed FWFT FIFO and streams it to the caster
// Optional STATE_FETCH_UNDERRUN_CNT_EN adds underrun_cnt (busy cycles where the caster was ready but no word was available).
module state_fetch #(
    parameter int                ADDR_W      = 30,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                FRAME_WORDS = 240000,
    parameter int                BURST_LEN   = 32,
    parameter int                FIFO_AW     = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_start,
    output logic busy,
    output logic err_overlap,
    output logic err_overflow,
`ifdef STATE_FETCH_UNDERRUN_CNT_EN
    output logic [15:0] underrun_cnt,
`endif
    state_fetch_if.master bus
);
    localparam int CW    = $clog2(FRAME_WORDS + 1);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int PW    = FIFO_AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      requested, delivered, remaining;
    logic [PW-1:0]      fifo_count, in_flight, credit;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]        mem [DEPTH];
    logic [6:0]         len;
    logic               issue, push, pop, full, last_pop;

    assign remaining = CW'(FRAME_WORDS) - requested;
    assign len       = (32'(remaining) < 32'(BURST_LEN)) ? 7'(remaining) : 7'(BURST_LEN);
    assign credit    = PW'(DEPTH) - fifo_count - in_flight;
    assign full      = fifo_count == PW'(DEPTH);
    assign pop       = bus.bi_valid && bus.bi_ready;
    assign push      = bus.rd_valid && (!full || pop);
    assign last_pop  = pop && delivered == CW'(FRAME_WORDS - 1);
    assign busy      = state != IDLE;

    assign bus.cmd_en   = issue;
    assign bus.cmd_addr = BASE_ADDR + ADDR_W'({requested, 2'b00});
    assign bus.cmd_bl   = issue ? 6'(len - 7'd1) : 6'd0;
    assign bus.bi_valid = fifo_count != '0;
    assign bus.bi_pixel = mem[rd_ptr];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next state and burst issue: a burst goes out only when the FIFO can absorb all of it
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        case (state)
            IDLE:  state_nx = frame_start ? REQ : IDLE;
            REQ: begin
                issue    = !bus.cmd_full && 32'(credit) >= 32'(len);
                state_nx = (issue && 32'(remaining) == 32'(len)) ? DRAIN : REQ;
            end
            DRAIN: state_nx = last_pop ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // frame progress counters and words owed by the controller
    always_ff @(posedge clk) begin
        if (rst) begin
            requested <= '0;
            delivered <= '0;
            in_flight <= '0;
        end else begin
            if (frame_start && !busy) begin
                requested <= '0;
                delivered <= '0;
            end else begin
                if (issue) requested <= requested + CW'(len);
                if (pop)   delivered <= delivered + 1'b1;
            end
            in_flight <= in_flight + (issue ? PW'(len) : '0) - PW'(bus.rd_valid);
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide even when full
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + PW'(push) - PW'(pop);
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.rd_data;
    end

    // sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            err_overlap  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            err_overlap  <= err_overlap | (frame_start & busy);
            err_overflow <= err_overflow | (bus.rd_valid & full & ~pop);
        end
    end

`ifdef STATE_FETCH_UNDERRUN_CNT_EN
    // saturating count of cycles the caster starved
    always_ff @(posedge clk) begin
        if (rst || (frame_start && !busy))                                 underrun_cnt <= '0;
        else if (busy && bus.bi_ready && !bus.bi_valid && ~&underrun_cnt) underrun_cnt <= underrun_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_state_fetch.sv
// tb_state_fetch: randomized bench with a memory-controller responder and a frame-level reference model
module tb_state_fetch;
    localparam int AW   = 30;
    localparam int FW   = 100;
    localparam int BL   = 32;
    localparam int FAW  = 6;
    localparam int BASE = 'h1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_start = 1'b0;
    logic busy, err_overlap, err_overflow;
`ifdef STATE_FETCH_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    state_fetch_if #(.ADDR_W(AW)) bus ();

    state_fetch #(
        .ADDR_W(AW), .BASE_ADDR(30'(BASE)), .FRAME_WORDS(FW), .BURST_LEN(BL), .FIFO_AW(FAW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .busy(busy),
        .err_overlap(err_overlap),
        .err_overflow(err_overflow),
`ifdef STATE_FETCH_UNDERRUN_CNT_EN
        .underrun_cnt(underrun_cnt),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // memory controller: in-order word returns after a per-burst latency, optional random gaps
    int lat_min = 4, lat_max = 4;
    bit gaps = 1'b0;
    int q_addr[$], q_rdy[$];
    initial begin
        int l;
        bus.rd_valid = 1'b0;
        bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_addr.delete();
                q_rdy.delete();
            end else if (bus.cmd_en) begin
                l = $urandom_range(lat_max, lat_min);
                for (int i = 0; i <= int'(bus.cmd_bl); i++) begin
                    q_addr.push_back(int'(bus.cmd_addr) + 4 * i);
                    q_rdy.push_back(cyc + l + i);
                end
            end
            @(posedge clk);
            #1;
            bus.rd_valid = 1'b0;
            if (q_addr.size() > 0 && q_rdy[0] <= cyc && !(gaps && $urandom_range(0, 3) == 0)) begin
                bus.rd_valid = 1'b1;
                bus.rd_data  = mem_word(q_addr.pop_front());
                void'(q_rdy.pop_front());
            end
        end
    end

    // caster readiness: 0 = always ready, 1 = never ready, 2 = random 50%
    int rdy_mode = 0;
    initial begin
        bus.bi_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.bi_ready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 0);
        end
    end

    // reference model and per-cycle compare
    bit m_busy = 1'b0, m_ovl = 1'b0, busy_now;
    int n_req = 0, n_pop = 0, n_cmd = 0, m_len;
    int log_addr[8], log_bl[8];
    int first_cmd_cyc = -1;
`ifdef STATE_FETCH_UNDERRUN_CNT_EN
    int m_und = 0;
`endif
    always @(negedge clk) begin
        busy_now = m_busy;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("err_overlap", 32'(err_overlap), 32'(m_ovl));
        chk("err_overflow", 32'(err_overflow), 0);
        if (bus.cmd_full || !m_busy) chk("cmd_en_blocked", 32'(bus.cmd_en), 0);
        if (!m_busy) chk("bi_valid_idle", 32'(bus.bi_valid), 0);
`ifdef STATE_FETCH_UNDERRUN_CNT_EN
        chk("underrun_cnt", 32'(underrun_cnt), 32'(m_und));
        if (rst || (frame_start && !busy_now)) m_und = 0;
        else if (busy_now && bus.bi_ready && !bus.bi_valid && m_und < 65535) m_und++;
`endif
        if (rst) begin
            m_busy = 1'b0;
            m_ovl  = 1'b0;
            n_req  = 0;
            n_pop  = 0;
            n_cmd  = 0;
        end else begin
            if (frame_start) begin
                if (busy_now) m_ovl = 1'b1;
                else begin
                    m_busy = 1'b1;
                    n_req = 0;
                    n_pop = 0;
                    n_cmd = 0;
                    first_cmd_cyc = -1;
                end
            end
            if (bus.cmd_en) begin
                m_len = (FW - n_req < BL) ? FW - n_req : BL;
                chk("cmd_in_frame", 32'(n_req < FW), 1);
                chk("cmd_addr", 32'(bus.cmd_addr), 32'(BASE + 4 * n_req));
                chk("cmd_bl", 32'(bus.cmd_bl), 32'(m_len - 1));
                chk("credit", 32'(n_req + m_len - n_pop <= 2 ** FAW), 1);
                if (n_cmd < 8) begin
                    log_addr[n_cmd] = int'(bus.cmd_addr);
                    log_bl[n_cmd]   = int'(bus.cmd_bl);
                end
                if (n_cmd == 0) first_cmd_cyc = cyc;
                n_cmd++;
                n_req += m_len;
            end
            if (bus.bi_valid && bus.bi_ready) begin
                chk("word_in_frame", 32'(n_pop < FW), 1);
                chk("bi_pixel", bus.bi_pixel, mem_word(BASE + 4 * n_pop));
                n_pop++;
                if (n_pop == FW) m_busy = 1'b0;
            end
        end
    end

    task automatic pulse_start();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic wait_idle(int max, string name);
        int n = 0;
        while (busy && n < max) begin
            tick(1);
            n++;
        end
        chk(name, 32'(busy), 0);
    endtask

    int rel;
    initial begin
        bus.cmd_full = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_bi_valid", 32'(bus.bi_valid), 0);
        chk("rst_cmd_en", 32'(bus.cmd_en), 0);
        chk("rst_cmd_addr", 32'(bus.cmd_addr), 'h1000);
        chk("rst_cmd_bl", 32'(bus.cmd_bl), 0);

        pulse_start();
        wait_idle(2000, "s1_timeout");
        chk("s1_ncmd", n_cmd, 4);
        chk("s1_addr0", log_addr[0], 'h1000);
        chk("s1_addr1", log_addr[1], 'h1080);
        chk("s1_addr2", log_addr[2], 'h1100);
        chk("s1_addr3", log_addr[3], 'h1180);
        chk("s1_bl0", log_bl[0], 31);
        chk("s1_bl2", log_bl[2], 31);
        chk("s1_bl3", log_bl[3], 3);
        chk("s1_words", n_pop, 100);

        rdy_mode = 1;
        pulse_start();
        tick(150);
        chk("s2_ncmd_stalled", n_cmd, 2);
        chk("s2_valid_stalled", 32'(bus.bi_valid), 1);
        rdy_mode = 0;
        wait_idle(2000, "s2_timeout");
        chk("s2_ncmd", n_cmd, 4);
        chk("s2_words", n_pop, 100);

        bus.cmd_full = 1'b1;
        pulse_start();
        tick(49);
        chk("s3_no_cmd", n_cmd, 0);
        bus.cmd_full = 1'b0;
        rel = cyc;
        wait_idle(2000, "s3_timeout");
        chk("s3_first_cmd", first_cmd_cyc, rel);

        chk("s4_ovl_before", 32'(err_overlap), 0);
        pulse_start();
        tick(30);
        pulse_start();
        wait_idle(2000, "s4_timeout");
        chk("s4_ovl", 32'(err_overlap), 1);
        chk("s4_words", n_pop, 100);

        do_reset();
        rdy_mode = 2;
        lat_min  = 2;
        lat_max  = 12;
        gaps     = 1'b1;
        repeat (5) begin
            pulse_start();
            wait_idle(5000, "s5_timeout");
            chk("s5_words", n_pop, 100);
            tick($urandom_range(0, 5));
        end

        pulse_start();
        rel = 0;
        while (n_pop < 37 && rel < 3000) begin
            tick(1);
            rel++;
        end
        chk("s6_reached_37", 32'(n_pop >= 37), 1);
        do_reset();
        chk("s6_busy", 32'(busy), 0);
        chk("s6_bi_valid", 32'(bus.bi_valid), 0);
        chk("s6_cmd_en", 32'(bus.cmd_en), 0);
        tick(3);
        pulse_start();
        wait_idle(5000, "s6_timeout");
        chk("s6_restart_addr", log_addr[0], 'h1000);
        chk("s6_words", n_pop, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
